// File: rtl/clock_run_ctrl.sv
// -----------------------------------------------------------------------------
// clock_run_ctrl
//
// Run-control sequencer for the CPU clock generator. It decides when the
// generator's ENABLE is high: continuous run, single step, N-cycle burst,
// host halt or CPU-initiated halt. It also counts the enabled cycles for
// bring-up and test.
//
// Ports
//   CLOCK        in   free-running reference clock, rising-edge active
//   RESET        in   asynchronous, active-high reset
//   RUN          in   level, continuous-run request
//   STEP         in   pulse, run exactly one enabled cycle
//   BURST_GO     in   pulse, run BURST_LEN enabled cycles
//   BURST_LEN    in   burst length, sampled only together with BURST_GO
//   HALT_REQ     in   host stop / halt acknowledge
//   CPU_HALT     in   CPU has executed a halt instruction
//   CLEAR_CNT    in   synchronous clear of CYCLE_COUNT
//   ENABLE       out  registered enable to the clock generator
//   BUSY         out  high whenever STATE is not IDLE
//   DONE         out  one-cycle completion pulse
//   CYCLE_COUNT  out  number of cycles with ENABLE=1 (wraps)
//   STATE        out  IDLE=00, RUN=01, BURST=10, HALTED=11
// -----------------------------------------------------------------------------
module clock_run_ctrl #(
  parameter int CNT_WIDTH   = 32,
  parameter int BURST_WIDTH = 16
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  input  logic                   RUN,
  input  logic                   STEP,
  input  logic                   BURST_GO,
  input  logic [BURST_WIDTH-1:0] BURST_LEN,
  input  logic                   HALT_REQ,
  input  logic                   CPU_HALT,
  input  logic                   CLEAR_CNT,
  output logic                   ENABLE,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [CNT_WIDTH-1:0]   CYCLE_COUNT,
  output logic [1:0]             STATE
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_BURST  = 2'b10,
    ST_HALTED = 2'b11
  } state_t;

  localparam logic [BURST_WIDTH-1:0] REM_ZERO = {BURST_WIDTH{1'b0}};
  localparam logic [BURST_WIDTH-1:0] REM_ONE  = {{(BURST_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]   CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_r;
  state_t                 state_s;
  logic [BURST_WIDTH-1:0] rem_r;
  logic [BURST_WIDTH-1:0] rem_s;
  logic                   done_s;
  logic                   enable_r;
  logic                   busy_r;
  logic                   done_r;
  logic [CNT_WIDTH-1:0]   count_r;

  // Helper: states in which the clock generator is enabled.
  function automatic logic is_enabled_state(input state_t st);
    is_enabled_state = (st == ST_RUN) || (st == ST_BURST);
  endfunction

  // Next-state, remaining-count and completion-event decode.
  always_comb begin
    state_s = state_r;
    rem_s   = rem_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (HALT_REQ) begin
          state_s = ST_IDLE;
        end else if (BURST_GO) begin
          if (BURST_LEN == REM_ZERO) begin
            // Zero-length burst completes at once without enabling.
            done_s = 1'b1;
          end else begin
            rem_s   = BURST_LEN;
            state_s = ST_BURST;
          end
        end else if (STEP) begin
          rem_s   = REM_ONE;
          state_s = ST_BURST;
        end else if (RUN) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (CPU_HALT) begin
          state_s = ST_HALTED;
          rem_s   = REM_ZERO;
          done_s  = 1'b1;
        end else if (HALT_REQ) begin
          state_s = ST_IDLE;
          rem_s   = REM_ZERO;
          done_s  = 1'b1;
        end else if (!RUN) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_BURST: begin
        // Halts take their own path even on the final burst cycle, so the
        // burst end and the halt share one DONE pulse.
        if (CPU_HALT) begin
          state_s = ST_HALTED;
          rem_s   = REM_ZERO;
          done_s  = 1'b1;
        end else if (HALT_REQ) begin
          state_s = ST_IDLE;
          rem_s   = REM_ZERO;
          done_s  = 1'b1;
        end else if (rem_r <= REM_ONE) begin
          // A zero remaining count is unreachable; treat it as the last cycle.
          state_s = ST_IDLE;
          rem_s   = REM_ZERO;
          done_s  = 1'b1;
        end else begin
          state_s = ST_BURST;
          rem_s   = rem_r - REM_ONE;
        end
      end
      ST_HALTED: begin
        if (HALT_REQ) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_HALTED;
        end
      end
      default: begin
        state_s = ST_IDLE;
        rem_s   = REM_ZERO;
      end
    endcase
  end

  // State and remaining-count registers.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_r <= ST_IDLE;
      rem_r   <= REM_ZERO;
    end else begin
      state_r <= state_s;
      rem_r   <= rem_s;
    end
  end

  // Registered Moore outputs, aligned with the state register.
  // A completion request while DONE is already high (only possible for a
  // zero-length burst right after another completion) is absorbed into the
  // current pulse so DONE never stays high for two cycles.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      enable_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      enable_r <= is_enabled_state(state_s);
      busy_r   <= (state_s != ST_IDLE);
      done_r   <= done_s & ~done_r;
    end
  end

  // Enabled-cycle counter; clear wins over increment.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      count_r <= CNT_ZERO;
    end else if (CLEAR_CNT) begin
      count_r <= CNT_ZERO;
    end else if (enable_r) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign ENABLE      = enable_r;
  assign BUSY        = busy_r;
  assign DONE        = done_r;
  assign CYCLE_COUNT = count_r;
  assign STATE       = state_r;

endmodule
